// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, arbiter FSM state encoding and
// a helper that tells whether a control code is one the ALU implements.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic alu_code_legal(input logic [3:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, wrapping ADD/SUB and signed set-less-than.
// Unsupported codes produce a zero result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALU_Ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  // Operation select; SLT compares as two's-complement values
  always_comb begin
    result = '0;
    case (ALU_Ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (ALU evaluates) -> RESP
// (response held until the granted requester takes it).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [3:0]       req_ctrl0,
  input  logic [3:0]       req_ctrl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  arb_state_e       state_q;
  logic             last_q;
  logic             gnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic             win_d;
  logic             accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Round-robin pick: a sole requester wins, a tie goes to the one not granted last
  always_comb begin
    win_d = 1'b0;
    if (req_valid == 2'b11) begin
      win_d = ~last_q;
    end else if (req_valid[1]) begin
      win_d = 1'b1;
    end
    req_ready = 2'b00;
    if (!rst && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = win_d ? 2'b10 : 2'b01;
    end
  end

  assign accept = |req_ready;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .ALU_Ctrl (ctrl_q),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  // Operand capture on accept; pure data, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= win_d ? req_a1 : req_a0;
      b_q    <= win_d ? req_b1 : req_b0;
      ctrl_q <= win_d ? req_ctrl1 : req_ctrl0;
    end
  end

  // Control FSM with registered response; reset drops any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q   <= win_d;
            last_q  <= win_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          err_q       <= ~alu_code_legal(ctrl_q);
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_ctrl0, req_ctrl1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ctrl0  (req_ctrl0),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU straight from the operation table
  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] c, output logic [W-1:0] r,
                                  output logic z, output logic e);
    e = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin r = '0; e = 1'b1; end
    endcase
    z = (r == '0);
  endfunction

  // Transaction model state
  bit           busy;
  int           g;
  int           acc_cyc;
  int           cyc;
  bit           last;
  logic [W-1:0] exp_res;
  logic         exp_zero, exp_err;
  bit           post_rst_chk;
  bit [1:0]     acc_now;
  bit           hs_now;
  int           hs_who;
  logic [W-1:0] hs_res;
  logic         hs_zero, hs_err;

  // Evaluate one cycle at the falling edge and advance the model past the next rising edge
  task automatic model_cycle();
    logic [1:0] exp_rv;
    logic [1:0] exp_rr;
    int         win;
    cyc++;
    if (post_rst_chk) begin
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_result", rsp_result, '0);
      check("rst_zero", rsp_zero, 1'b0);
      check("rst_err", rsp_err, 1'b0);
      post_rst_chk = 0;
    end
    exp_rv = (busy && cyc >= acc_cyc + 2) ? (2'b01 << g) : 2'b00;
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != 2'b00) begin
      check("rsp_result", rsp_result, exp_res);
      check("rsp_zero", rsp_zero, exp_zero);
      check("rsp_err", rsp_err, exp_err);
    end
    win = 0;
    if (req_valid == 2'b11) win = last ? 0 : 1;
    else if (req_valid[1]) win = 1;
    exp_rr = (rst || busy || req_valid == 2'b00) ? 2'b00 : (2'b01 << win);
    check("req_ready", req_ready, exp_rr);
    acc_now = 2'b00;
    hs_now  = 0;
    if (rst) begin
      busy = 0;
      last = 1;
      post_rst_chk = 1;
    end else begin
      if (exp_rv != 2'b00 && rsp_ready[g]) begin
        hs_now  = 1;
        hs_who  = g;
        hs_res  = rsp_result;
        hs_zero = rsp_zero;
        hs_err  = rsp_err;
        busy    = 0;
      end
      if (exp_rr != 2'b00) begin
        busy    = 1;
        g       = win;
        last    = (win == 1);
        acc_cyc = cyc;
        acc_now[win] = 1'b1;
        if (win == 1) ref_alu(req_a1, req_b1, req_ctrl1, exp_res, exp_zero, exp_err);
        else          ref_alu(req_a0, req_b0, req_ctrl0, exp_res, exp_zero, exp_err);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc_now[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c);
    if (i == 0) begin req_a0 = a; req_b0 = b; req_ctrl0 = c; end
    else        begin req_a1 = a; req_b1 = b; req_ctrl1 = c; end
    req_valid[i] = 1'b1;
  endtask

  // Run until a response handshake, then compare it against literal values
  task automatic wait_hs(input string tag, input int who, input logic [W-1:0] r,
                         input logic z, input logic e);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      if (hs_now) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_who"}, hs_who, who);
      check({tag, "_res"}, hs_res, r);
      check({tag, "_zero"}, hs_zero, z);
      check({tag, "_err"}, hs_err, e);
    end
  endtask

  function automatic logic [3:0] rand_ctrl();
    logic [3:0] c;
    case ($urandom_range(0, 5))
      0: c = 4'b0000;
      1: c = 4'b0001;
      2: c = 4'b0010;
      3: c = 4'b0110;
      4: c = 4'b0111;
      default: c = 4'($urandom);
    endcase
    return c;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0: v = W'($urandom_range(0, 7));
      1: v = {W{1'b1}} - W'($urandom_range(0, 3));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_ctrl0 = '0; req_ctrl1 = '0;
    busy = 0; last = 1; cyc = 0; g = 0; acc_cyc = 0;
    post_rst_chk = 1; acc_now = 2'b00; hs_now = 0;
    repeat (2) @(posedge clk);
    #1;
    // Contention right after reset: requester 0 wins while rst still high is ignored
    set_req(0, 5, 3, 4'b0000);
    set_req(1, 5, 3, 4'b0001);
    step();
    rst = 1'b0;
    wait_hs("cont_and", 0, 1, 1'b0, 1'b0);
    wait_hs("cont_or", 1, 7, 1'b0, 1'b0);
    set_req(0, 5, 3, 4'b0010);
    set_req(1, 5, 5, 4'b0110);
    wait_hs("add", 0, 8, 1'b0, 1'b0);
    wait_hs("sub0", 1, 0, 1'b1, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 3, 4'b0111);
    wait_hs("slt", 1, 1, 1'b0, 1'b0);
    set_req(0, 5, 3, 4'b1111);
    wait_hs("illegal", 0, 0, 1'b1, 1'b1);

    // Back-pressure: only the non-granted requester's ready is high
    rsp_ready = 2'b10;
    set_req(0, 32'h1234, 32'h0F0F, 4'b0001);
    for (int n = 0; n < 6; n++) begin
      step();
      if (n == 1) set_req(1, 9, 4, 4'b0110);
    end
    check("bp_still_busy", busy, 1'b1);
    rsp_ready = 2'b01;
    wait_hs("bp_or", 0, 32'h1F3F, 1'b0, 1'b0);
    rsp_ready = 2'b11;
    wait_hs("bp_after", 1, 5, 1'b0, 1'b0);

    // Reset during EXEC abandons the operation
    set_req(0, 7, 7, 4'b0010);
    step();
    check("midrst_acc", acc_now, 2'b01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("midrst_no_hs", hs_now, 1'b0);
    end

    // Randomized traffic with occasional resets and back-pressure
    for (int n = 0; n < 600; n++) begin
      step();
      rst = ($urandom_range(0, 79) == 0);
      rsp_ready = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, rand_opnd(), rand_opnd(), rand_ctrl());
      end
    end
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
